// File: rtl/du.sv
// du: iterative restoring divider, signed or unsigned, one quotient bit per cycle.
// Latency: WIDTH+2 cycles from the start cycle to the done pulse; the latency is fixed, including for divide-by-zero.
// Backpressure: busy=1 while an operation is in flight, and start is ignored then; a start in the done cycle is accepted.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, sgn, A, B    request, signed-mode select, dividend, divisor (sampled when accepted)
//   Quotient, Remainder registered results; saturated on overflow or divide-by-zero
//   busy, done          in-flight indicator; one-cycle result-valid pulse
//   v, n, z             overflow/div0, negative (signed mode only), zero-quotient flags
module du #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             v,
    output logic             n,
    output logic             z
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    LAST_IT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operation context, latched at accept.
    logic             sgn_q;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             special;

    // Iteration state: dvd starts as |A| and is shifted out at the top while
    // quotient bits are shifted in at the bottom, so it ends up holding |Q|.
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dvd;
    logic [CW-1:0]    cnt;

    logic accept;
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: if (cnt == LAST_IT) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = start ? S_CALC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_CALC,
            S_FIX:  busy = 1'b1;
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning at accept
    // ------------------------------------------------------------------
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_abs_in;
    logic [WIDTH-1:0] b_abs_in;

    always_comb begin
        a_neg_in = sgn & A[WIDTH-1];
        b_neg_in = sgn & B[WIDTH-1];
        // The most negative value maps to itself, which is the correct
        // magnitude when it is read back as unsigned.
        a_abs_in = a_neg_in ? (~A + 1'b1) : A;
        b_abs_in = b_neg_in ? (~B + 1'b1) : B;
    end

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           trial_ok;

    always_comb begin
        // Because prem < |B| always holds, the shifted value is below 2*|B|
        // and fits in WIDTH+1 bits, so a top-bit check on trial is a sign test.
        shifted  = {prem, dvd[WIDTH-1]};
        trial    = shifted - {1'b0, b_abs};
        trial_ok = ~trial[WIDTH];
    end

    // ------------------------------------------------------------------
    // Sign correction and saturation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic             fix_v;

    always_comb begin
        fix_q = (sa ^ sb) ? (~dvd + 1'b1) : dvd;
        fix_r = sa ? (~prem + 1'b1) : prem;
        fix_v = 1'b0;
        if (div_zero) begin
            // The magnitude path ran to completion anyway (with all ones),
            // but its result is discarded in favour of the saturated value.
            fix_v = 1'b1;
            fix_r = a_raw;
            if (!sgn_q) begin
                fix_q = ALL_ONE;
            end else if (sa) begin
                fix_q = MIN_NEG;
            end else begin
                fix_q = MAX_POS;
            end
        end else if (special) begin
            fix_v = 1'b1;
            fix_q = MAX_POS;
            fix_r = '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_q     <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            a_raw     <= '0;
            b_abs     <= '0;
            div_zero  <= 1'b0;
            special   <= 1'b0;
            prem      <= '0;
            dvd       <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            v         <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
        end else begin
            if (accept) begin
                sgn_q    <= sgn;
                sa       <= a_neg_in;
                sb       <= b_neg_in;
                a_raw    <= A;
                b_abs    <= b_abs_in;
                div_zero <= (B == '0);
                special  <= sgn && (A == MIN_NEG) && (B == ALL_ONE);
                prem     <= '0;
                dvd      <= a_abs_in;
                cnt      <= '0;
            end else if (state == S_CALC) begin
                prem <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                dvd  <= {dvd[WIDTH-2:0], trial_ok};
                cnt  <= cnt + 1'b1;
            end else if (state == S_FIX) begin
                Quotient  <= fix_q;
                Remainder <= fix_r;
                v         <= fix_v;
                n         <= sgn_q & fix_q[WIDTH-1];
                z         <= (fix_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_du.sv
module tb_du;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        v;
    logic        n;
    logic        z;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    du #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sgn       (sgn),
        .A         (a),
        .B         (b),
        .Quotient  (quotient),
        .Remainder (remainder),
        .busy      (busy),
        .done      (done),
        .v         (v),
        .n         (n),
        .z         (z)
    );

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        v;
        logic        n;
        logic        z;
    } res_t;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        res_t        exp;
    } vec_t;

    // Reference: plain integer division (truncating, remainder follows dividend)
    // with the saturation rules layered on top.
    function automatic res_t model(input logic s, input logic [15:0] av, input logic [15:0] bv);
        res_t o;
        int   si;
        int   di;
        o = '0;
        if (bv == 16'h0000) begin
            o.v = 1'b1;
            o.r = av;
            if (!s)        o.q = 16'hFFFF;
            else if (av[15]) o.q = 16'h8000;
            else           o.q = 16'h7FFF;
        end else if (s && av == 16'h8000 && bv == 16'hFFFF) begin
            o.v = 1'b1;
            o.q = 16'h7FFF;
            o.r = 16'h0000;
        end else if (s) begin
            si  = $signed(av);
            di  = $signed(bv);
            o.q = 16'(si / di);
            o.r = 16'(si % di);
        end else begin
            o.q = av / bv;
            o.r = av % bv;
        end
        o.n = s & o.q[15];
        o.z = (o.q == 16'h0000);
        return o;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d]: got %h, required %h", nm, idx, got, exp);
        end
    endtask

    task automatic check_res(input string nm, input int idx, input res_t e);
        check({nm, ".q"}, idx, 32'(quotient),  32'(e.q));
        check({nm, ".r"}, idx, 32'(remainder), 32'(e.r));
        check({nm, ".v"}, idx, 32'(v), 32'(e.v));
        check({nm, ".n"}, idx, 32'(n), 32'(e.n));
        check({nm, ".z"}, idx, 32'(z), 32'(e.z));
    endtask

    // Present a request for one cycle, then return at the first negedge after the accepting edge.
    task automatic issue(input logic s, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        sgn   = s;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles from the start cycle (cycle 0) until done; bounded.
    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!done && lat < 60) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs[8];
    int   lat;
    int   bc;
    res_t e;
    res_t e2;
    int   dones;

    initial begin
        vecs[0] = '{1'b1, 16'h0064, 16'h0007, '{16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{1'b1, 16'hFF9C, 16'h0007, '{16'hFFF2, 16'hFFFE, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0002, '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0}};
        vecs[3] = '{1'b1, 16'hFFF0, 16'h0000, '{16'h8000, 16'hFFF0, 1'b1, 1'b1, 1'b0}};
        vecs[4] = '{1'b1, 16'h0005, 16'h0000, '{16'h7FFF, 16'h0005, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{1'b0, 16'h0005, 16'h0000, '{16'hFFFF, 16'h0005, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{1'b1, 16'h8000, 16'hFFFF, '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0}};
        vecs[7] = '{1'b1, 16'h0003, 16'h0007, '{16'h0000, 16'h0003, 1'b0, 1'b0, 1'b1}};

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset.q",    0, 32'(quotient),  0);
        check("reset.r",    0, 32'(remainder), 0);
        check("reset.flags", 0, 32'({busy, done, v, n, z}), 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(lat, bc);
            check("tbl.lat",  i, 32'(lat), 18);
            check("tbl.busy", i, 32'(bc),  17);
            check_res("tbl", i, vecs[i].exp);
        end

        // start pulses at cycles 5 and 10 must be ignored; outputs hold until FIX
        issue(1'b1, 16'h0064, 16'h0007);
        lat = 1;
        while (!done && lat < 60) begin
            if (lat == 5) check("hold.q", 0, 32'(quotient), 32'(vecs[7].exp.q));
            start = (lat == 5 || lat == 10);
            if (start) begin
                sgn = 1'b0;
                a   = 16'(lat * 1111);
                b   = 16'(lat);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("ign.lat", 0, 32'(lat), 18);
        check_res("ign", 0, vecs[0].exp);

        // start held in the done cycle: back-to-back
        issue(1'b1, 16'hFF9C, 16'h0007);
        wait_done(lat, bc);
        check("b2b.lat", 0, 32'(lat), 18);
        check_res("b2b", 0, vecs[1].exp);
        sgn   = 1'b0;
        a     = 16'd50000;
        b     = 16'd123;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("b2b.lat", 1, 32'(lat), 18);
        check_res("b2b", 1, model(1'b0, 16'd50000, 16'd123));

        // Reset at cycle 9 of an operation: silent abort
        issue(1'b1, 16'h0064, 16'h0007);
        lat = 1;
        while (lat < 9) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.q", 0, 32'(quotient),  0);
        check("rstmid.r", 0, 32'(remainder), 0);
        check("rstmid.flags", 0, 32'({busy, done, v, n, z}), 0);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("rstmid.nodone", 0, 32'(dones), 0);
        issue(1'b1, 16'hFF9C, 16'h0007);
        wait_done(lat, bc);
        check("postrst.lat", 0, 32'(lat), 18);
        check_res("postrst", 0, vecs[1].exp);

        // Randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            logic        s;
            logic [15:0] av;
            logic [15:0] bv;
            int          sel;
            s   = 1'($urandom);
            av  = 16'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0: bv = 16'h0000;
                1: begin av = 16'h8000; bv = 16'hFFFF; end
                2: bv = 16'($urandom_range(1, 20));
                3: bv = 16'hFFFF - 16'($urandom_range(0, 20));
                default: bv = 16'($urandom);
            endcase
            e2 = model(s, av, bv);
            issue(s, av, bv);
            wait_done(lat, bc);
            check("rnd.lat", i, 32'(lat), 18);
            check_res("rnd", i, e2);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
